xy_route_stage: RTL and testbench
=================================

Name: xy_route_stage

Overview:
- Registered, parametrised successor to the combinational X-only local-injection splitter.
- Buffers packets from one input in a FIFO, routes each in dimension order (XY or YX) to one of five outputs (E, W, N, S, Local), and moves the signed dx/dy fields one step toward zero on the chosen hop.
- Uses valid/ready handshakes on both sides.
- Sits at every router input port, between the link receiver and the crossbar.

Parameters:
- PKT_W, 16: packet width in bits.
- COORD_W, 4: width of each signed coordinate field.
- DEPTH, 4: FIFO entries, power of two, at least 2.
- YX_FIRST, 0: 0 = route X then Y; 1 = route Y then X.

Ports:
- clk  in  1: clock.
- rst  in  1: synchronous, active-high reset.
- in_pkt  in  PKT_W: packet. dx = [PKT_W-1 -: COORD_W], dy = [PKT_W-COORD_W-1 -: COORD_W], both two's complement; remaining bits are payload.
- in_valid  in  1: input packet valid.
- in_ready  out  1: stage can accept.
- out_pkt  out  PKT_W: routed packet with updated coordinates.
- out_valid  out  5: one-hot request, bit order [0]=E [1]=W [2]=N [3]=S [4]=L.
- out_ready  in  5: per-destination ready, same bit order.
- occupancy  out  $clog2(DEPTH+2): packets held (FIFO plus output register).

Behaviour:
- Reset and clock: only clk; reset is synchronous and active-high.
- Reset values: out_valid=0, out_pkt=0, occupancy=0, FIFO pointers=0. in_ready is 1 in the first cycle after reset is released; it is 0 while rst is high.
- Reset mid-operation: all buffered packets are discarded with no partial output. out_valid drops on the edge that samples rst=1.
- Input accept: in_valid && in_ready at a rising edge writes in_pkt to the FIFO tail. in_ready = !fifo_full, combinational from registered count only. It does not depend on a same-cycle pop, so there is no write-through when full.
- Output register (OR): one entry. OR loads from the FIFO head when OR is empty or OR fires this cycle, and the FIFO is non-empty. The FIFO pops on the same edge. FIFO-to-OR has no bypass.
- Latency: a packet accepted at edge k is visible on out_* after edge k+1 when the stage is idle, i.e. 2 cycles from in_valid to out_valid.
- Fire condition: |(out_valid & out_ready). Only the asserted bit's ready matters. Ready on other bits is ignored.
- Stall: while not fired, out_pkt and out_valid hold stable.
- Routing decision, computed on the FIFO head as it enters OR (XY order, YX_FIRST=0):
  - dx>0: E, dx-1.
  - dx<0: W, dx+1.
  - dx==0 and dy>0: N, dy-1.
  - dx==0 and dy<0: S, dy+1.
  - both zero: L, packet unmodified.
- YX_FIRST=1: the same rules with the dy tests first.
- Arithmetic:
  - Sign-extend to COORD_W+1, add or subtract, truncate to COORD_W.
  - Moves are always toward zero, so there is no overflow. The most negative value -2^(COORD_W-1) increments normally.
  - Only the coordinate field on the routed axis changes. Payload and the other coordinate pass unchanged.
- Ordering: strict FIFO order across all destinations. A blocked head blocks later packets (head-of-line; no reordering).
- FIFO boundaries:
  - Pointers are log2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH.
  - Full = pointers' MSBs differ and the rest are equal. Empty = pointers equal.
  - Simultaneous push and pop when neither full nor empty leaves the count unchanged.
- Capacity: DEPTH + 1 packets.
- occupancy = fifo_count + OR valid, updated every edge.

Decomposition:
- router_pkg holds:
  - localparams for port indices (PORT_E=0, PORT_W=1, PORT_N=2, PORT_S=3, PORT_L=4) and NUM_PORTS=5;
  - a function that extracts signed dx/dy for given PKT_W/COORD_W;
  - a function step_toward_zero(coord).
- One sub-module, sync_fifo (WIDTH, DEPTH; push/pop/full/empty/count, synchronous reset). Routing and the output register stay in the top level.

Test Plan (PKT_W=16, COORD_W=4, DEPTH=4):
- XY routing: in 16'h32AB with out_ready=5'b11111 -> 2 cycles later out_valid=5'b00001, out_pkt=16'h22AB. Then in 16'hF0CD -> out_valid=5'b00010, out_pkt=16'h00CD.
- Y axis and local: 16'h0E11 -> out_valid=5'b01000, out_pkt=16'h0F11. 16'h0055 -> out_valid=5'b10000, out_pkt=16'h0055. 16'h8000 -> W, out_pkt=16'h9000.
- YX_FIRST=1: 16'h32AB -> out_valid=5'b00100, out_pkt=16'h31AB.
- Backpressure: out_ready=0 and 8 back-to-back valid inputs -> exactly 5 accepted, in_ready=0, occupancy=5, out_pkt stable. Then out_ready=5'b11111 -> 5 outputs in input order, one per cycle, and in_ready re-asserts after the first fire.
- Wrong-port ready: head routed E with out_ready=5'b11110 -> no fire for 10 cycles. Then set out_ready[0]=1 -> fires in that cycle.
- Reset mid-stream: rst=1 for 1 cycle with occupancy=3 -> the next cycle shows out_valid=0, occupancy=0, and no stale packet appears afterwards.

Source files
------------

// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : router_pkg
// Description : Shared port indices and coordinate helpers for the XY route
//               stage: signed dx/dy extraction and one-step-toward-zero.
// Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

  localparam int PORT_E    = 0;
  localparam int PORT_W    = 1;
  localparam int PORT_N    = 2;
  localparam int PORT_S    = 3;
  localparam int PORT_L    = 4;
  localparam int NUM_PORTS = 5;

  // Helpers work on fixed maximum widths; callers size-cast in and slice out.
  localparam int MAX_PKT_W   = 64;
  localparam int MAX_COORD_W = 16;
  localparam int PKT_IDX_W   = 6;

  // Extract a coord_w-bit two's complement field whose MSB sits at bit msb,
  // sign-extended to MAX_COORD_W bits.
  function automatic logic signed [MAX_COORD_W-1:0] extract_coord(
    input logic [MAX_PKT_W-1:0] pkt,
    input int                   msb,
    input int                   coord_w
  );
    logic signed [MAX_COORD_W-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_COORD_W; i++) begin
      if (i < coord_w) begin
        v[i] = pkt[PKT_IDX_W'(msb - coord_w + 1 + i)];
      end else begin
        v[i] = pkt[PKT_IDX_W'(msb)];
      end
    end
    return v;
  endfunction

  function automatic logic signed [MAX_COORD_W-1:0] extract_dx(
    input logic [MAX_PKT_W-1:0] pkt,
    input int                   pkt_w,
    input int                   coord_w
  );
    return extract_coord(pkt, pkt_w - 1, coord_w);
  endfunction

  function automatic logic signed [MAX_COORD_W-1:0] extract_dy(
    input logic [MAX_PKT_W-1:0] pkt,
    input int                   pkt_w,
    input int                   coord_w
  );
    return extract_coord(pkt, pkt_w - coord_w - 1, coord_w);
  endfunction

  // Move a coordinate one step toward zero. Widening by one bit before the
  // add/subtract keeps the most negative value well behaved.
  function automatic logic signed [MAX_COORD_W-1:0] step_toward_zero(
    input logic signed [MAX_COORD_W-1:0] coord
  );
    logic signed [MAX_COORD_W:0] ext;
    ext = {coord[MAX_COORD_W-1], coord};
    if (coord[MAX_COORD_W-1]) begin
      ext = ext + (MAX_COORD_W+1)'(1);
    end else if (coord != '0) begin
      ext = ext - (MAX_COORD_W+1)'(1);
    end
    return ext[MAX_COORD_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Synchronous FIFO with extra-bit wrap pointers; full/empty and
//               count derive from registered pointers only.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int c_ADDR_W = $clog2(DEPTH);

  logic [c_ADDR_W:0] r_wr_ptr;
  logic [c_ADDR_W:0] r_rd_ptr;
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic              w_do_push;
  logic              w_do_pop;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]) &&
                     (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]);
  assign count     = r_wr_ptr - r_rd_ptr;
  assign pop_data  = r_mem[r_rd_ptr[c_ADDR_W-1:0]];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Pointer update; both pointers wrap modulo 2*DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + {{c_ADDR_W{1'b0}}, 1'b1};
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + {{c_ADDR_W{1'b0}}, 1'b1};
    end
  end

  // Storage write; contents are qualified by the pointers so need no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/xy_route_stage.sv
`default_nettype none
// ============================================================================
// Module      : xy_route_stage
// Description : Router input stage: FIFO buffer, dimension-order route
//               decision with coordinate decrement, one-entry output register
//               with a one-hot valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module xy_route_stage
  import router_pkg::*;
#(
  parameter int PKT_W    = 16,
  parameter int COORD_W  = 4,
  parameter int DEPTH    = 4,
  parameter int YX_FIRST = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PKT_W-1:0]              in_pkt,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [PKT_W-1:0]              out_pkt,
  output logic [NUM_PORTS-1:0]          out_valid,
  input  logic [NUM_PORTS-1:0]          out_ready,
  output logic [$clog2(DEPTH+2)-1:0]    occupancy
);

  localparam int c_OCC_W = $clog2(DEPTH+2);
  localparam int c_SIGN  = MAX_COORD_W - 1;

  logic                          w_fifo_full;
  logic                          w_fifo_empty;
  logic [$clog2(DEPTH):0]        w_fifo_count;
  logic [PKT_W-1:0]              w_head;
  logic [MAX_PKT_W-1:0]          w_head_ext;
  logic signed [MAX_COORD_W-1:0] w_dx;
  logic signed [MAX_COORD_W-1:0] w_dy;
  logic signed [MAX_COORD_W-1:0] w_dx_step;
  logic signed [MAX_COORD_W-1:0] w_dy_step;
  logic                          w_use_x;
  logic                          w_use_y;
  logic [NUM_PORTS-1:0]          w_next_valid;
  logic [PKT_W-1:0]              w_next_pkt;
  logic                          w_push;
  logic                          w_fire;
  logic                          w_or_full;
  logic                          w_load;
  logic                          w_unused;

  logic [NUM_PORTS-1:0]          r_out_valid;
  logic [PKT_W-1:0]              r_out_pkt;

  // Accept depends only on registered FIFO state, never on a same-cycle pop.
  assign in_ready  = !w_fifo_full && !rst;
  assign w_push    = in_valid && in_ready;
  assign w_or_full = |r_out_valid;
  assign w_fire    = |(r_out_valid & out_ready);
  assign w_load    = (!w_or_full || w_fire) && !w_fifo_empty;

  sync_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (in_pkt),
    .pop       (w_load),
    .pop_data  (w_head),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .count     (w_fifo_count)
  );

  assign w_head_ext = MAX_PKT_W'(w_head);
  assign w_dx       = extract_dx(w_head_ext, PKT_W, COORD_W);
  assign w_dy       = extract_dy(w_head_ext, PKT_W, COORD_W);
  assign w_dx_step  = step_toward_zero(w_dx);
  assign w_dy_step  = step_toward_zero(w_dy);
  assign w_unused   = ^{w_head_ext, w_dx_step, w_dy_step};

  // Route decision on the FIFO head: pick axis by order, direction by sign,
  // and rewrite only the routed coordinate field.
  always_comb begin
    w_use_x      = 1'b0;
    w_use_y      = 1'b0;
    w_next_valid = '0;
    w_next_pkt   = w_head;
    if (YX_FIRST == 0) begin
      w_use_x = (w_dx != '0);
      w_use_y = (w_dx == '0) && (w_dy != '0);
    end else begin
      w_use_y = (w_dy != '0);
      w_use_x = (w_dy == '0) && (w_dx != '0);
    end
    if (w_use_x) begin
      if (w_dx[c_SIGN]) w_next_valid[PORT_W] = 1'b1;
      else              w_next_valid[PORT_E] = 1'b1;
      w_next_pkt[PKT_W-1 -: COORD_W] = w_dx_step[COORD_W-1:0];
    end else if (w_use_y) begin
      if (w_dy[c_SIGN]) w_next_valid[PORT_S] = 1'b1;
      else              w_next_valid[PORT_N] = 1'b1;
      w_next_pkt[PKT_W-COORD_W-1 -: COORD_W] = w_dy_step[COORD_W-1:0];
    end else begin
      w_next_valid[PORT_L] = 1'b1;
    end
  end

  // Output register: reload from the FIFO head when free or firing, else
  // clear on fire; holds stable while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= '0;
      r_out_pkt   <= '0;
    end else if (w_load) begin
      r_out_valid <= w_next_valid;
      r_out_pkt   <= w_next_pkt;
    end else if (w_fire) begin
      r_out_valid <= '0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_pkt   = r_out_pkt;
  assign occupancy = c_OCC_W'(w_fifo_count) + c_OCC_W'(w_or_full);

endmodule
`default_nettype wire

// File: tb/tb_xy_route_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_xy_route_stage
// Description : Directed self-checking bench for xy_route_stage (XY and YX
//               instances, 16-bit packets, 4-bit coordinates, depth 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xy_route_stage;

  logic        clk;
  logic        rst;
  logic [15:0] in_pkt;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_pkt;
  logic [4:0]  out_valid;
  logic [4:0]  out_ready;
  logic [2:0]  occupancy;

  logic [15:0] yx_in_pkt;
  logic        yx_in_valid;
  logic        yx_in_ready;
  logic [15:0] yx_out_pkt;
  logic [4:0]  yx_out_valid;
  logic [4:0]  yx_out_ready;
  logic [2:0]  yx_occupancy;

  int errors = 0;
  int checks = 0;

  xy_route_stage #(.PKT_W(16), .COORD_W(4), .DEPTH(4), .YX_FIRST(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_pkt    (in_pkt),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_pkt   (out_pkt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  xy_route_stage #(.PKT_W(16), .COORD_W(4), .DEPTH(4), .YX_FIRST(1)) dut_yx (
    .clk       (clk),
    .rst       (rst),
    .in_pkt    (yx_in_pkt),
    .in_valid  (yx_in_valid),
    .in_ready  (yx_in_ready),
    .out_pkt   (yx_out_pkt),
    .out_valid (yx_out_valid),
    .out_ready (yx_out_ready),
    .occupancy (yx_occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Push one packet into the XY instance with all outputs ready and check
  // it appears two edges later on the expected port.
  task automatic route_one(input string tag, input logic [15:0] pkt,
                           input logic [4:0] exp_v, input logic [15:0] exp_pkt);
    in_pkt   = pkt;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_lat"}, {27'd0, out_valid}, 32'd0);
    tick();
    check({tag, "_valid"}, {27'd0, out_valid}, {27'd0, exp_v});
    check({tag, "_pkt"}, {16'd0, out_pkt}, {16'd0, exp_pkt});
    tick();
  endtask

  initial begin
    int accepted;
    logic saw_valid;
    rst = 1'b1;
    in_pkt = '0; in_valid = 1'b0; out_ready = 5'b11111;
    yx_in_pkt = '0; yx_in_valid = 1'b0; yx_out_ready = 5'b11111;
    tick();
    tick();

    // Reset state
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {27'd0, out_valid}, 32'd0);
    check("rst_out_pkt", {16'd0, out_pkt}, 32'd0);
    check("rst_occ", {29'd0, occupancy}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    tick();

    // XY routing, all four directions plus local and most-negative dx
    route_one("east",  16'h32AB, 5'b00001, 16'h22AB);
    route_one("west",  16'hF0CD, 5'b00010, 16'h00CD);
    route_one("south", 16'h0E11, 5'b01000, 16'h0F11);
    route_one("local", 16'h0055, 5'b10000, 16'h0055);
    route_one("minneg",16'h8000, 5'b00010, 16'h9000);
    route_one("north", 16'h0311, 5'b00100, 16'h0211);

    // YX order on the second instance
    yx_in_pkt   = 16'h32AB;
    yx_in_valid = 1'b1;
    tick();
    yx_in_valid = 1'b0;
    tick();
    check("yx_valid", {27'd0, yx_out_valid}, 32'h04);
    check("yx_pkt", {16'd0, yx_out_pkt}, 32'h31AB);
    tick();
    check("yx_drained", {27'd0, yx_out_valid}, 32'd0);

    // Backpressure: 8 back-to-back offers, only 5 fit
    out_ready = 5'b00000;
    accepted  = 0;
    for (int i = 0; i < 8; i++) begin
      in_pkt   = 16'h10A0 + 16'(i);
      in_valid = 1'b1;
      if (in_ready) accepted++;
      tick();
    end
    in_valid = 1'b0;
    check("bp_accepted", accepted, 32'd5);
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_occ", {29'd0, occupancy}, 32'd5);
    check("bp_hold_valid", {27'd0, out_valid}, 32'h01);
    check("bp_hold_pkt", {16'd0, out_pkt}, 32'h00A0);
    tick();
    check("bp_hold_pkt2", {16'd0, out_pkt}, 32'h00A0);
    out_ready = 5'b11111;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("drain%0d_valid", i), {27'd0, out_valid}, 32'h01);
      check($sformatf("drain%0d_pkt", i), {16'd0, out_pkt}, 32'h00A0 + i);
      tick();
      if (i == 0) check("drain_in_ready", {31'd0, in_ready}, 32'd1);
    end
    check("drain_empty_valid", {27'd0, out_valid}, 32'd0);
    check("drain_empty_occ", {29'd0, occupancy}, 32'd0);

    // Ready on the wrong port must not fire an east-bound head
    out_ready = 5'b11110;
    in_pkt    = 16'h10B0;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    tick();
    repeat (10) tick();
    check("wp_valid", {27'd0, out_valid}, 32'h01);
    check("wp_pkt", {16'd0, out_pkt}, 32'h00B0);
    check("wp_occ", {29'd0, occupancy}, 32'd1);
    out_ready[0] = 1'b1;
    tick();
    check("wp_fired_valid", {27'd0, out_valid}, 32'd0);
    check("wp_fired_occ", {29'd0, occupancy}, 32'd0);

    // Reset mid-stream discards everything
    out_ready = 5'b00000;
    for (int i = 0; i < 3; i++) begin
      in_pkt   = 16'h10C0 + 16'(i);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("mid_occ", {29'd0, occupancy}, 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", {27'd0, out_valid}, 32'd0);
    check("mid_rst_occ", {29'd0, occupancy}, 32'd0);
    out_ready = 5'b11111;
    saw_valid = 1'b0;
    repeat (4) begin
      tick();
      if (out_valid != 5'b0) saw_valid = 1'b1;
    end
    check("mid_no_stale", {31'd0, saw_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
